// File: rtl/axi_eth_tx_mux.sv
// Round-robin Ethernet TX arbiter: grants one client, emits its 14-byte L2 header,
// forwards the client's payload and zero-pads short frames up to MIN_FRAME bytes.
module axi_eth_tx_mux #(
    parameter int N_PORTS   = 4,
    parameter int MIN_FRAME = 60,
    parameter int PAD_EN    = 1
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic [N_PORTS-1:0]      req,
    output logic [N_PORTS-1:0]      ack,
    input  logic [48*N_PORTS-1:0]   dst_mac,
    input  logic [48*N_PORTS-1:0]   src_mac,
    input  logic [16*N_PORTS-1:0]   ethertype,
    input  logic [8*N_PORTS-1:0]    s_axis_tdata,
    input  logic [N_PORTS-1:0]      s_axis_tlast,
    input  logic [N_PORTS-1:0]      s_axis_tvalid,
    output logic [N_PORTS-1:0]      s_axis_tready,
    output logic [7:0]              m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    busy,
    output logic [31:0]             tx_frames
);

    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [N_PORTS-1:0] ONE_HOT0 = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        PAD     = 2'd3
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [PW-1:0]     grant;
    logic [PW-1:0]     pick;
    logic [PW-1:0]     cand;
    logic              found;
    int                idx;
    logic [10:0]       count;
    logic [10:0]       count_n;
    logic [10:0]       count_inc;
    logic [111:0]      hdr;
    logic [7:0]        hdr_byte;
    logic              long_enough;
    logic              beat;
    logic              frame_done;

    // Round-robin search starting one past the last granted port, with wrap.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        idx   = 0;
        for (int i = 1; i <= N_PORTS; i++) begin
            idx  = (int'(grant) + i) % N_PORTS;
            cand = PW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // count doubles as the header byte index while in HEADER (0..13).
    always_comb begin
        hdr_byte = '0;
        for (int b = 0; b < 14; b++) begin
            if (count[3:0] == 4'(b)) hdr_byte = hdr[8*(13-b) +: 8];
        end
    end

    assign count_inc   = (count == 11'h7FF) ? count : count + 11'd1;
    assign long_enough = (PAD_EN == 0) || (({1'b0, count} + 12'd1) >= 12'(MIN_FRAME));
    assign busy        = (state != IDLE);

    // Handshake: a byte moves on a rising clk edge where tvalid && tready; a
    // sender holding tvalid keeps tdata/tlast stable until that edge.
    always_comb begin
        state_n       = state;
        count_n       = count;
        frame_done    = 1'b0;
        beat          = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = HEADER;
                    count_n = '0;
                end
            end
            HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_byte;
                if (m_axis_tready) begin
                    count_n = count_inc;
                    if (count == 11'd13) state_n = PAYLOAD;
                end
            end
            PAYLOAD: begin
                m_axis_tvalid        = s_axis_tvalid[grant];
                m_axis_tdata         = s_axis_tdata[8*grant +: 8];
                m_axis_tlast         = s_axis_tlast[grant] && long_enough;
                s_axis_tready[grant] = m_axis_tready;
                beat                 = s_axis_tvalid[grant] && m_axis_tready;
                if (beat) begin
                    count_n = count_inc;
                    if (s_axis_tlast[grant]) begin
                        if (long_enough) begin
                            state_n    = IDLE;
                            frame_done = 1'b1;
                        end else begin
                            state_n = PAD;
                        end
                    end
                end
            end
            PAD: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (count == 11'(MIN_FRAME - 1));
                if (m_axis_tready) begin
                    count_n = count_inc;
                    if (m_axis_tlast) begin
                        state_n    = IDLE;
                        frame_done = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // grant also serves as the round-robin pointer; reset makes port 0 win first.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            grant     <= PW'(N_PORTS - 1);
            count     <= '0;
            hdr       <= '0;
            ack       <= '0;
            tx_frames <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            ack   <= '0;
            if (state == IDLE && found) begin
                grant <= pick;
                ack   <= ONE_HOT0 << pick;
                hdr   <= {dst_mac[48*pick +: 48], src_mac[48*pick +: 48],
                          ethertype[16*pick +: 16]};
            end
            if (frame_done) tx_frames <= tx_frames + 32'd1;
        end
    end

endmodule

// File: doc/axi_eth_tx_mux.md
Name: axi_eth_tx_mux

Overview:
N-port Ethernet TX arbiter and header inserter with minimum-frame padding. Sits between the UDP/ARP/ICMP frame builders and the MAC TX AXI-Stream.
- Grants one requesting port at a time, round-robin.
- Snapshots that port's header fields at grant and emits the 14-byte L2 header, then the port's payload.
- Zero-pads short frames up to MIN_FRAME bytes (FCS excluded; the MAC appends it).

Parameters:
N_PORTS, 4, number of client ports (1..8)
MIN_FRAME, 60, minimum emitted frame length in bytes including header, excluding FCS
PAD_EN, 1, 1 = pad short frames with 0x00; 0 = never pad

Ports:
clk  in  1  clock
aresetn  in  1  asynchronous active-low reset
req  in  N_PORTS  per-port transmit request, held high until ack
ack  out  N_PORTS  one-cycle grant pulse, one-hot
dst_mac  in  48*N_PORTS  per-port destination MAC, port i at [48*i+:48], MSB sent first
src_mac  in  48*N_PORTS  per-port source MAC, same packing as dst_mac
ethertype  in  16*N_PORTS  per-port EtherType, MSB sent first
s_axis_tdata  in  8*N_PORTS  per-port payload byte
s_axis_tlast  in  N_PORTS  per-port payload last
s_axis_tvalid  in  N_PORTS  per-port payload valid
s_axis_tready  out  N_PORTS  per-port payload ready
m_axis_tdata  out  8  frame byte to MAC
m_axis_tlast  out  1  last frame byte
m_axis_tvalid  out  1  frame byte valid
m_axis_tready  in  1  MAC ready
busy  out  1  high in any state other than IDLE
tx_frames  out  32  count of completed frames, wraps modulo 2^32

Behaviour:
- Reset (asynchronous, immediate), all outputs 0:
  - state=IDLE, last-grant pointer=N_PORTS-1 (so port 0 wins first), tx_frames=0.
- Reset mid-frame abandons the frame: m_axis_tvalid drops at once and no partial frame is resumed.
- States: IDLE, HEADER, PAYLOAD, PAD.
- IDLE:
  - If any req bit is set, pick the first set bit searching from last+1 with wrap.
  - The next cycle: state=HEADER, ack[g]=1 for exactly that cycle, last=g.
  - Latch dst_mac/src_mac/ethertype of port g into internal registers; later changes on those inputs are ignored.
  - Latency: req seen in cycle n gives the first header byte valid in cycle n+1.
- HEADER:
  - m_axis_tvalid=1, tlast=0, tdata=latched header byte idx, where idx 0-5 is dst, 6-11 is src, 12-13 is ethertype.
  - idx advances only on m_axis_tready; after the handshake at idx 13, state=PAYLOAD and byte count=14.
  - All s_axis_tready are 0 in this state.
- PAYLOAD:
  - m_axis_tdata/tvalid follow port g combinationally; s_axis_tready[g]=m_axis_tready, all other tready are 0.
  - Each handshake increments count (11 bits, saturating at 2047).
  - On a handshake with s_axis_tlast[g]:
    - If PAD_EN=0 or count+1>=MIN_FRAME: m_axis_tlast=1 on that beat, then state=IDLE and tx_frames+1.
    - Otherwise m_axis_tlast=0 on that beat, then state=PAD.
  - A payload must be at least one byte; a single beat carrying tlast is legal.
- PAD:
  - m_axis_tvalid=1, tdata=0x00; count increments on each handshake.
  - m_axis_tlast=1 when count==MIN_FRAME-1; that handshake sends state=IDLE and tx_frames+1.
  - s_axis_tready=0 in this state.
- After each frame the block spends exactly one IDLE cycle before the next header byte.
- m_axis_tvalid is never deasserted in HEADER or PAD without a handshake; in PAYLOAD it follows the source's own tvalid.
- If req drops before grant, it is simply not considered. Requests arriving during a frame wait until IDLE.
- A req bit still high in the cycle ack is issued is not double-granted: the pointer has moved, so the port waits its round-robin turn.

Test Plan:
- Port 0 req, dst=02:00:00:00:00:01, src=02:00:00:00:00:02, type 0x0800, 46-byte payload -> exactly 60 bytes out; first 14 bytes match the header; tlast on byte 60; ack[0] pulses once; tx_frames=1.
- Port 2, 10-byte payload, PAD_EN=1 -> 14 header + 10 payload + 36 bytes of 0x00; tlast only on byte 60; s_axis_tready[2]=0 during PAD.
- Same as the previous case with PAD_EN=0 -> 24-byte frame with tlast on byte 24.
- All four req held high, last grant port 0 -> grant order 1,2,3,0; one IDLE cycle between frames; header fields of each port are correct even when the inputs change after ack.
- m_axis_tready toggling 1-0-1 during HEADER and PAD -> no byte is skipped or duplicated; tvalid is held and tdata is stable while tready=0.
- aresetn pulsed low mid-PAYLOAD -> outputs 0 immediately; after release a new req is granted to port 0 and the frame is complete and correct; tx_frames=0 until that frame finishes.
